wb_bus_arbiter: RTL and testbench

- Two-master to one-slave Wishbone arbiter directly downstream of the core's instruction (iwbm) and data (dwbm) ports.
- Merges both ports onto a single memory/interconnect bus.
- Arbitrates with round-robin tie-break, holds a grant for the whole transaction, and terminates stuck transactions with a watchdog error.

---
 rtl/wb_bus_arbiter_pkg.sv | 6 +
 rtl/wb_bus_arbiter_watchdog.sv | 18 +
 rtl/wb_bus_arbiter.sv | 83 ++++++++
 tb/tb_wb_bus_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_bus_arbiter_pkg.sv
// wb_bus_arbiter_pkg: arbiter state encoding and master index constants
package wb_bus_arbiter_pkg;
  typedef enum logic [1:0] {ARB_IDLE, ARB_BUSY_M0, ARB_BUSY_M1} arb_state_t;
  localparam logic ARB_M0 = 1'b0;
  localparam logic ARB_M1 = 1'b1;
endpackage

// File: rtl/wb_bus_arbiter_watchdog.sv
// wb_watchdog: saturating busy-cycle counter (clear on grant, run while waiting, hit on last allowed cycle)
module wb_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clear,
  input  logic run,
  output logic hit
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i || clear) cnt <= '0;
    else if (run && cnt != W'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
  end
  assign hit = (TIMEOUT_CYCLES != 0) && run && cnt == W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/wb_bus_arbiter.sv
// wb_bus_arbiter: round-robin m0 (instr) / m1 (data) Wishbone masters onto one slave s_*, with watchdog abort
module wb_bus_arbiter
  import wb_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic [31:0] m0_addr_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_dat_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i
);
  arb_state_t state, state_n;
  logic last_grant, last_grant_n;
  logic req0, req1, grant, pick1, busy0, busy1, busy, resp, hit, cyc_g, stb_g;
  assign req0  = m0_cyc_i & m0_stb_i;
  assign req1  = m1_cyc_i & m1_stb_i;
  assign busy0 = state == ARB_BUSY_M0 && !rst_i;
  assign busy1 = state == ARB_BUSY_M1 && !rst_i;
  assign busy  = busy0 | busy1;
  assign resp  = s_ack_i | s_err_i;
  assign grant = state == ARB_IDLE && (req0 || req1);
  assign pick1 = req1 && (!req0 || last_grant == ARB_M0);
  assign cyc_g = busy1 ? m1_cyc_i : m0_cyc_i;
  assign stb_g = busy1 ? m1_stb_i : m0_stb_i;
  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    if (grant) begin
      state_n      = pick1 ? ARB_BUSY_M1 : ARB_BUSY_M0;
      last_grant_n = pick1 ? ARB_M1 : ARB_M0;
    end else if (busy && (resp || hit || !cyc_g)) state_n = ARB_IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ARB_IDLE;
      last_grant <= ARB_M0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
    end
  end
  wb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_wdg (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clear (grant),
    .run   (busy && !resp),
    .hit   (hit)
  );
  assign s_cyc_o  = busy && cyc_g && !hit;
  assign s_stb_o  = busy && stb_g && !hit;
  assign s_we_o   = busy1 && m1_we_i;
  assign s_sel_o  = busy1 ? m1_sel_i : busy0 ? 4'hF : 4'h0;
  assign s_addr_o = busy1 ? m1_addr_i : busy0 ? m0_addr_i : 32'h0;
  assign s_dat_o  = busy1 ? m1_dat_i : 32'h0;
  assign m0_ack_o = busy0 && s_ack_i && !s_err_i;
  assign m1_ack_o = busy1 && s_ack_i && !s_err_i;
  assign m0_err_o = busy0 && (s_err_i || hit);
  assign m1_err_o = busy1 && (s_err_i || hit);
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;
endmodule

// File: tb/tb_wb_bus_arbiter.sv
// tb_wb_bus_arbiter: directed stimulus with a transaction-level reference model and literal spot checks
module tb_wb_bus_arbiter;
  localparam int T = 16;
  localparam logic [31:0] A0 = 32'h8000_0000;
  localparam logic [31:0] A1 = 32'h0000_0200;
  logic clk = 1'b0, rst = 1'b1;
  logic m0_cyc = 0, m0_stb = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m1_addr = 0, m1_dat = 0, s_dat_i = 0;
  logic [3:0] m1_sel = 0;
  logic s_ack_i = 0, s_err_i = 0;
  logic [31:0] m0_dat_o, m1_dat_o, s_addr_o, s_dat_o;
  logic m0_ack_o, m0_err_o, m1_ack_o, m1_err_o, s_cyc_o, s_stb_o, s_we_o;
  logic [3:0] s_sel_o;
  int checks = 0, errors = 0, cyc_n = 0, bc;
  int owner = -1, last = 0, elapsed = 0;
  logic to, c, prev_cyc = 0;
  logic e_cyc, e_stb, e_we;
  logic [3:0] e_sel;
  logic [31:0] e_addr, e_dat;
  logic [1:0] e_ack, e_err;
  logic glog[$];
  int gcyc[$];

  wb_bus_arbiter #(.TIMEOUT_CYCLES(T)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_addr_i(m0_addr),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_addr_i(m1_addr), .m1_dat_i(m1_dat),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_addr_o(s_addr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
    .s_ack_i(s_ack_i), .s_err_i(s_err_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", n, cyc_n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    m0_cyc = 0; m0_stb = 0; m1_cyc = 0; m1_stb = 0; m1_we = 0; m1_sel = 0;
    m1_dat = 0; s_ack_i = 0; s_err_i = 0; s_dat_i = 0;
  endtask

  always @(negedge clk) begin
    e_cyc = 0; e_stb = 0; e_we = 0; e_sel = 0; e_addr = 0; e_dat = 0; e_ack = 0; e_err = 0;
    if (rst) begin
      owner = -1; last = 0; elapsed = 0;
    end else if (owner >= 0) begin
      to = elapsed == T - 1 && !s_ack_i && !s_err_i;
      c = owner == 1 ? m1_cyc : m0_cyc;
      e_cyc = c && !to;
      e_stb = (owner == 1 ? m1_stb : m0_stb) && !to;
      e_we = owner == 1 && m1_we;
      e_sel = owner == 1 ? m1_sel : 4'hF;
      e_addr = owner == 1 ? m1_addr : m0_addr;
      e_dat = owner == 1 ? m1_dat : 32'h0;
      e_ack[owner] = s_ack_i && !s_err_i;
      e_err[owner] = s_err_i || to;
      if (s_ack_i || s_err_i || to || !c) owner = -1;
      else elapsed++;
    end else if ((m0_cyc && m0_stb) || (m1_cyc && m1_stb)) begin
      owner = (m0_cyc && m0_stb && m1_cyc && m1_stb) ? 1 - last : (m1_cyc && m1_stb ? 1 : 0);
      last = owner;
      elapsed = 0;
    end
    chk("s_cyc", s_cyc_o, e_cyc);
    chk("s_stb", s_stb_o, e_stb);
    chk("s_we", s_we_o, e_we);
    chk("s_sel", s_sel_o, e_sel);
    chk("s_addr", s_addr_o, e_addr);
    chk("s_dat", s_dat_o, e_dat);
    chk("acks", {m1_ack_o, m0_ack_o}, e_ack);
    chk("errs", {m1_err_o, m0_err_o}, e_err);
    chk("m0_dat", m0_dat_o, s_dat_i);
    chk("m1_dat", m1_dat_o, s_dat_i);
    if (s_cyc_o && !prev_cyc) begin
      glog.push_back(s_addr_o == A1);
      gcyc.push_back(cyc_n);
    end
    prev_cyc = s_cyc_o;
  end

  initial begin
    step(); step();
    rst = 0;
    @(negedge clk);
    chk("reset_cyc", s_cyc_o, 0);
    chk("reset_addr", s_addr_o, 0);
    // m0 read, ack in the third busy cycle
    step();
    m0_cyc = 1; m0_stb = 1; m0_addr = A0;
    @(negedge clk);
    chk("t1_c0_cyc", s_cyc_o, 0);
    step();
    @(negedge clk);
    chk("t1_c1_cyc", s_cyc_o, 1);
    chk("t1_c1_we", s_we_o, 0);
    chk("t1_c1_sel", s_sel_o, 4'hF);
    chk("t1_c1_addr", s_addr_o, A0);
    step();
    step();
    s_ack_i = 1; s_dat_i = 32'h13;
    @(negedge clk);
    chk("t1_c3_ack", m0_ack_o, 1);
    chk("t1_c3_dat", m0_dat_o, 32'h13);
    step();
    idle_all();
    @(negedge clk);
    chk("t1_c4_idle", s_cyc_o, 0);
    // both masters request right after reset, slave acks in second busy cycle
    rst = 1;
    step();
    rst = 0;
    glog.delete(); gcyc.delete();
    m0_cyc = 1; m0_stb = 1; m0_addr = A0;
    m1_cyc = 1; m1_stb = 1; m1_addr = A1;
    bc = 0;
    for (int i = 0; i < 13; i++) begin
      step();
      bc = s_cyc_o ? bc + 1 : 0;
      s_ack_i = bc == 2;
    end
    @(negedge clk);
    chk("rr_count", glog.size() >= 4, 1);
    if (glog.size() >= 4) begin
      chk("rr_g0_m1", glog[0], 1);
      chk("rr_g1_m0", glog[1], 0);
      chk("rr_g2_m1", glog[2], 1);
      chk("rr_g3_m0", glog[3], 0);
      chk("rr_gap", gcyc[1] - gcyc[0], 3);
    end
    step();
    idle_all();
    step();
    // m1 write, simultaneous ack and err
    m1_cyc = 1; m1_stb = 1; m1_we = 1; m1_sel = 4'b0011; m1_addr = A1; m1_dat = 32'hDEADBEEF;
    step();
    s_ack_i = 1; s_err_i = 1;
    @(negedge clk);
    chk("t4_we", s_we_o, 1);
    chk("t4_sel", s_sel_o, 4'h3);
    chk("t4_dat", s_dat_o, 32'hDEADBEEF);
    chk("t4_err", m1_err_o, 1);
    chk("t4_ack", m1_ack_o, 0);
    step();
    idle_all();
    step();
    // silent slave: watchdog fires on the 16th busy cycle
    m1_cyc = 1; m1_stb = 1; m1_addr = A1;
    for (int k = 1; k <= 16; k++) begin
      step();
      @(negedge clk);
      if (k == 15) chk("wd_c15_err", m1_err_o, 0);
      if (k == 16) begin
        chk("wd_c16_err", m1_err_o, 1);
        chk("wd_c16_cyc", s_cyc_o, 0);
      end
    end
    step();
    idle_all();
    m0_cyc = 1; m0_stb = 1; m0_addr = A0;
    step();
    s_ack_i = 1; s_dat_i = 32'h55;
    @(negedge clk);
    chk("wd_after_addr", s_addr_o, A0);
    chk("wd_after_ack", m0_ack_o, 1);
    step();
    idle_all();
    step();
    // abort: m0 drops cyc, late ack not forwarded
    m0_cyc = 1; m0_stb = 1;
    step();
    m0_cyc = 0; m0_stb = 0;
    @(negedge clk);
    chk("abort_cyc", s_cyc_o, 0);
    step();
    s_ack_i = 1;
    @(negedge clk);
    chk("abort_late_ack", m0_ack_o, 0);
    step();
    idle_all();
    step();
    // reset during BUSY_M0 with ack pending
    m0_cyc = 1; m0_stb = 1; m0_addr = A0;
    step();
    rst = 1; s_ack_i = 1;
    @(negedge clk);
    chk("rst_ack", m0_ack_o, 0);
    step();
    rst = 0; s_ack_i = 0;
    m1_cyc = 1; m1_stb = 1; m1_addr = A1;
    @(negedge clk);
    chk("rst_next_cyc", s_cyc_o, 0);
    step();
    @(negedge clk);
    chk("rst_regrant_m1", s_addr_o, A1);
    step();
    idle_all();
    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
